// File: rtl/mem_arbiter_if.sv
// Shared bus between the icache/dcache requesters, the arbiter and the RAM model.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic        dwait;
   logic [31:0] dload;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic [1:0]  ramstate;
   logic        err;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (icache/dcache) to single-RAM arbiter, dcache priority with icache anti-starvation.
// Grant is registered (1 cycle), completion combinational on ACCESS; RAM BUSY/FREE stalls indefinitely.
module mem_arbiter #(
   parameter int STARVE_MAX = 4
) (
   input  logic          CLK,
   input  logic          nRST,
   mem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, DSERV, ISERV} state_t;

   localparam logic [1:0] RAM_ACCESS = 2'd2;
   localparam logic [1:0] RAM_ERROR  = 2'd3;
   localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

   state_t     r_state;
   state_t     w_next;
   logic [2:0] r_starve;
   logic [2:0] w_starve_next;
   logic       r_err;
   logic       w_err_set;
   logic       w_dreq;

   assign w_dreq  = bus.dREN | bus.dWEN;
   assign bus.err = r_err;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state  <= IDLE;
         r_starve <= '0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_starve <= w_starve_next;
         r_err    <= r_err | w_err_set;
      end
   end

   always_comb begin
      w_next        = r_state;
      w_starve_next = r_starve;
      w_err_set     = 1'b0;
      bus.ramREN    = 1'b0;
      bus.ramWEN    = 1'b0;
      bus.ramaddr   = '0;
      bus.ramstore  = '0;
      bus.iwait     = 1'b1;
      bus.dwait     = 1'b1;
      bus.iload     = '0;
      bus.dload     = '0;

      case (r_state)
         IDLE: begin
            if (!bus.iREN)
               w_starve_next = '0;
            // icache jumps the queue once dcache has won STARVE_MAX times in a row
            if (w_dreq && !(bus.iREN && (r_starve >= STARVE_LIM)))
               w_next = DSERV;
            else if (bus.iREN)
               w_next = ISERV;
         end

         DSERV: begin
            if (!w_dreq) begin
               w_next = IDLE;
            end else begin
               bus.ramaddr  = bus.daddr;
               bus.ramstore = bus.dstore;
               bus.ramWEN   = bus.dWEN;
               bus.ramREN   = !bus.dWEN;
               if (bus.ramstate == RAM_ACCESS) begin
                  bus.dwait = 1'b0;
                  bus.dload = bus.dWEN ? 32'd0 : bus.ramload;
                  w_next    = IDLE;
                  if (bus.iREN && (r_starve != 3'd7))
                     w_starve_next = r_starve + 3'd1;
               end else if (bus.ramstate == RAM_ERROR) begin
                  w_err_set = 1'b1;
                  w_next    = IDLE;
               end
            end
         end

         ISERV: begin
            if (!bus.iREN) begin
               w_next = IDLE;
            end else begin
               bus.ramaddr = bus.iaddr;
               bus.ramREN  = 1'b1;
               if (bus.ramstate == RAM_ACCESS) begin
                  bus.iwait     = 1'b0;
                  bus.iload     = bus.ramload;
                  w_next        = IDLE;
                  w_starve_next = '0;
               end else if (bus.ramstate == RAM_ERROR) begin
                  w_err_set = 1'b1;
                  w_next    = IDLE;
               end
            end
         end

         default: w_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: grant order, starvation, stalls, errors, reset.
module tb_mem_arbiter;

   logic CLK;
   logic nRST;
   int   n_total;
   int   n_pass;
   logic [1:0] exp_w [11];

   mem_arbiter_if bus ();

   mem_arbiter #(.STARVE_MAX(4)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge CLK);
      #2;
   endtask

   initial begin
      n_total      = 0;
      n_pass       = 0;
      nRST         = 1'b0;
      bus.iREN     = 1'b0;
      bus.iaddr    = '0;
      bus.dREN     = 1'b0;
      bus.dWEN     = 1'b0;
      bus.daddr    = '0;
      bus.dstore   = '0;
      bus.ramload  = '0;
      bus.ramstate = 2'd0;
      // {iwait,dwait} per cycle with dWEN and iREN held and RAM always ready
      exp_w = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10};

      #3;
      chk("rst_ramREN", bus.ramREN, 0);
      chk("rst_ramWEN", bus.ramWEN, 0);
      chk("rst_iwait",  bus.iwait,  1);
      chk("rst_dwait",  bus.dwait,  1);
      chk("rst_loads",  bus.iload | bus.dload, 0);
      chk("rst_err",    bus.err,    0);
      chk("rst_ramaddr", bus.ramaddr, 0);
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      nRST = 1'b1;

      // single icache read
      bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramstate = 2'd2; bus.ramload = 32'hDEADBEEF;
      #1;
      chk("i1_idle_ramREN", bus.ramREN, 0);
      chk("i1_idle_iwait",  bus.iwait,  1);
      cyc();
      chk("i1_ramREN",  bus.ramREN,  1);
      chk("i1_ramaddr", bus.ramaddr, 32'h40);
      chk("i1_iwait",   bus.iwait,   0);
      chk("i1_iload",   bus.iload,   32'hDEADBEEF);
      chk("i1_dwait",   bus.dwait,   1);
      chk("i1_dload",   bus.dload,   0);
      cyc();
      bus.iREN = 1'b0;
      #1;
      chk("i1_after_ramREN", bus.ramREN, 0);
      chk("i1_after_iwait",  bus.iwait,  1);
      chk("i1_after_iload",  bus.iload,  0);

      // simultaneous requests: dcache first, then icache after an idle cycle
      bus.iREN = 1'b1; bus.iaddr = 32'h44; bus.dREN = 1'b1; bus.daddr = 32'h80; bus.ramload = 32'h11112222;
      cyc();
      chk("both_d_ramREN",  bus.ramREN,  1);
      chk("both_d_ramWEN",  bus.ramWEN,  0);
      chk("both_d_ramaddr", bus.ramaddr, 32'h80);
      chk("both_d_dwait",   bus.dwait,   0);
      chk("both_d_dload",   bus.dload,   32'h11112222);
      chk("both_d_iwait",   bus.iwait,   1);
      chk("both_d_iload",   bus.iload,   0);
      cyc();
      bus.dREN = 1'b0;
      #1;
      chk("both_idle_ramREN", bus.ramREN, 0);
      chk("both_idle_iwait",  bus.iwait,  1);
      cyc();
      chk("both_i_ramaddr", bus.ramaddr, 32'h44);
      chk("both_i_iwait",   bus.iwait,   0);
      chk("both_i_iload",   bus.iload,   32'h11112222);
      chk("both_i_dwait",   bus.dwait,   1);
      cyc();
      bus.iREN = 1'b0;

      // anti-starvation: four dcache writes, then icache, then dcache again
      bus.iREN = 1'b1; bus.iaddr = 32'h48; bus.dWEN = 1'b1; bus.daddr = 32'h200; bus.dstore = 32'hA5A5A5A5;
      for (int i = 0; i < 11; i++) begin
         cyc();
         chk($sformatf("starve_waits_%0d", i), {bus.iwait, bus.dwait}, exp_w[i]);
         chk($sformatf("starve_wen_%0d", i), bus.ramWEN, (exp_w[i] == 2'b10) ? 1 : 0);
      end
      cyc();
      bus.iREN = 1'b0; bus.dWEN = 1'b0;

      // write stalled by BUSY for three cycles; write wins over read
      bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'h12345678;
      bus.ramstate = 2'd1; bus.ramload = 32'hFFFFFFFF;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk($sformatf("busy_wen_%0d", i),   bus.ramWEN, 1);
         chk($sformatf("busy_ren_%0d", i),   bus.ramREN, 0);
         chk($sformatf("busy_dwait_%0d", i), bus.dwait,  1);
      end
      chk("busy_ramaddr",  bus.ramaddr,  32'h100);
      chk("busy_ramstore", bus.ramstore, 32'h12345678);
      cyc();
      bus.ramstate = 2'd2;
      #1;
      chk("wr_done_wen",   bus.ramWEN, 1);
      chk("wr_done_dwait", bus.dwait,  0);
      chk("wr_done_dload", bus.dload,  0);
      cyc();
      bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.ramstate = 2'd0;

      // RAM error during icache service; err is sticky until reset
      bus.iREN = 1'b1; bus.iaddr = 32'h60; bus.ramstate = 2'd3;
      cyc();
      chk("err_serv_ramREN", bus.ramREN, 1);
      chk("err_serv_iwait",  bus.iwait,  1);
      chk("err_serv_err",    bus.err,    0);
      cyc();
      chk("err_idle_err",    bus.err,    1);
      chk("err_idle_ramREN", bus.ramREN, 0);
      chk("err_idle_iwait",  bus.iwait,  1);
      cyc();
      chk("err_retry_ramREN", bus.ramREN, 1);
      chk("err_retry_err",    bus.err,    1);
      chk("err_retry_iwait",  bus.iwait,  1);
      bus.iREN = 1'b0; bus.ramstate = 2'd0; nRST = 1'b0;
      #1;
      chk("err_rst_err",    bus.err,    0);
      chk("err_rst_ramREN", bus.ramREN, 0);
      @(negedge CLK);
      nRST = 1'b1;
      cyc();
      chk("err_post_err",    bus.err,    0);
      chk("err_post_ramREN", bus.ramREN, 0);

      // reset in the middle of a stalled dcache write
      bus.dWEN = 1'b1; bus.daddr = 32'h300; bus.dstore = 32'h1; bus.ramstate = 2'd1;
      cyc();
      chk("midrst_pre_wen", bus.ramWEN, 1);
      nRST = 1'b0;
      #1;
      chk("midrst_wen",   bus.ramWEN, 0);
      chk("midrst_ren",   bus.ramREN, 0);
      chk("midrst_dwait", bus.dwait,  1);
      bus.ramstate = 2'd2;
      #1;
      chk("midrst_access_dwait", bus.dwait, 1);
      chk("midrst_access_dload", bus.dload, 0);
      bus.dWEN = 1'b0;
      @(negedge CLK);
      nRST = 1'b1;
      cyc();
      chk("midrst_post_wen",   bus.ramWEN, 0);
      chk("midrst_post_dwait", bus.dwait,  1);

      // dcache withdraws its request mid-service: no completion
      bus.dREN = 1'b1; bus.daddr = 32'h20; bus.ramstate = 2'd1;
      cyc();
      chk("wd_ramREN",  bus.ramREN,  1);
      chk("wd_ramaddr", bus.ramaddr, 32'h20);
      bus.dREN = 1'b0;
      #1;
      chk("wd_dwait", bus.dwait, 1);
      cyc();
      bus.ramstate = 2'd2;
      #1;
      chk("wd_idle_ramREN", bus.ramREN,  0);
      chk("wd_idle_dwait",  bus.dwait,   1);
      chk("wd_idle_addr",   bus.ramaddr, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
